uart_tx_fifo: RTL and testbench

UART_TX_FIFO -- requirements
Module: uart_tx_fifo

---
 rtl/uart_tx_fifo.sv | 181 ++++++++++++++++++
 tb/tb_uart_tx_fifo.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: byte FIFO feeding an 8N1 UART serializer.
// Optional even-parity bit (8E1 frames) when UART_TX_PARITY_EN is defined.
// tx_pin is registered from the current state. It therefore follows the
// state machine by one cycle.
`timescale 1ns/1ps

module uart_tx_fifo #(
    parameter int unsigned CLK_DIV    = 104,
    parameter int unsigned DEPTH_LOG2 = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       fifo_write_req,
    input  logic [7:0] fifo_write_data,
    output logic       full,
    output logic       tx_pin,
    output logic       tx_busy
);

    localparam int unsigned DEPTH  = 1 << DEPTH_LOG2;
    localparam int unsigned CW     = DEPTH_LOG2 + 1;
    localparam int unsigned BAUD_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [BAUD_W-1:0] BAUD_LAST  = BAUD_W'(CLK_DIV - 1);
    localparam logic [CW-1:0]     COUNT_FULL = CW'(DEPTH);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_TX_PARITY_EN
        PARITY,
`endif
        STOP
    } state_t;

    logic [7:0]            mem_q [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         count_q, count_d;
    logic                  full_q, full_d;

    state_t                state_q, state_d;
    logic [BAUD_W-1:0]     baud_q, baud_d;
    logic [2:0]            bit_q, bit_d;
    logic [7:0]            shift_q, shift_d;
    logic                  tx_q, tx_d;

    logic                  wr_accept;
    logic                  pop;
    logic                  baud_done;

    // Writes are gated by the registered full flag, i.e. the pre-edge count.
    assign wr_accept = fifo_write_req && !full_q;
    assign baud_done = (baud_q == BAUD_LAST);

    assign full    = full_q;
    assign tx_pin  = tx_q;
    assign tx_busy = (state_q != IDLE);

    // FIFO storage: data only, no reset needed.
    always_ff @(posedge clk) begin
        if (wr_accept) begin
            mem_q[wr_ptr_q] <= fifo_write_data;
        end
    end

    // FIFO pointer/occupancy next state; full is precomputed from the next count.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (wr_accept) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({wr_accept, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        full_d = (count_d == COUNT_FULL);
    end

    // FIFO control registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= full_d;
        end
    end

    // Serializer next state, pop request and line level for the current state.
    always_comb begin
        state_d = state_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        pop     = 1'b0;
        tx_d    = 1'b1;
        case (state_q)
            IDLE: begin
                tx_d = 1'b1;
                if (count_q != '0) begin
                    pop     = 1'b1;
                    shift_d = mem_q[rd_ptr_q];
                    state_d = START;
                end
            end
            START: begin
                tx_d = 1'b0;
                if (baud_done) begin
                    bit_d   = '0;
                    state_d = DATA;
                end
            end
            DATA: begin
                tx_d = shift_q[bit_q];
                if (baud_done) begin
                    if (bit_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                tx_d = ^shift_q;
                if (baud_done) begin
                    state_d = STOP;
                end
            end
`endif
            STOP: begin
                tx_d = 1'b1;
                if (baud_done) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if ((state_d != state_q) || baud_done || (state_q == IDLE)) begin
            baud_d = '0;
        end else begin
            baud_d = baud_q + 1'b1;
        end
    end

    // Serializer registers; tx line is forced high by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo at CLK_DIV=104, DEPTH_LOG2=4.
// Define UART_TX_PARITY_EN for both files to exercise 8E1 frames.
`timescale 1ns/1ps

module tb_uart_tx_fifo;

    localparam int CLK_DIV = 104;
`ifdef UART_TX_PARITY_EN
    localparam int FRAME_BITS = 11;
`else
    localparam int FRAME_BITS = 10;
`endif

    logic       clk;
    logic       rst_n;
    logic       fifo_write_req;
    logic [7:0] fifo_write_data;
    logic       full;
    logic       tx_pin;
    logic       tx_busy;

    int tests_run;
    int tests_failed;

    uart_tx_fifo #(
        .CLK_DIV    (CLK_DIV),
        .DEPTH_LOG2 (4)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .fifo_write_req  (fifo_write_req),
        .fifo_write_data (fifo_write_data),
        .full            (full),
        .tx_pin          (tx_pin),
        .tx_busy         (tx_busy)
    );

    always #5 clk = ~clk;

    // Single-cycle write; called at a negedge, returns at the negedge after the accepting edge.
    task automatic write_byte(input logic [7:0] d);
        fifo_write_req  = 1'b1;
        fifo_write_data = d;
        @(negedge clk);
        fifo_write_req  = 1'b0;
    endtask

    // Checks one whole frame; the current negedge is the first start-bit sample.
    // Returns at the negedge holding the last stop-bit sample.
    task automatic check_frame(input logic [7:0] data, input logic par, input string name);
        logic exp_bit;
        int   good;
        tests_run++;
        if (tx_busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL %s_busy: tx_busy=%b required 1", name, tx_busy);
        end
        for (int b = 0; b < FRAME_BITS; b++) begin
            if (b == 0)                    exp_bit = 1'b0;
            else if (b <= 8)               exp_bit = data[b-1];
            else if (b == FRAME_BITS - 1)  exp_bit = 1'b1;
            else                           exp_bit = par;
            good = 0;
            for (int c = 0; c < CLK_DIV; c++) begin
                if (!(b == 0 && c == 0)) @(negedge clk);
                if (tx_pin === exp_bit) good++;
            end
            tests_run++;
            if (good != CLK_DIV) begin
                tests_failed++;
                $display("FAIL %s_bit%0d: %0d cycles at level %b, required %0d", name, b, good, exp_bit, CLK_DIV);
            end
        end
    endtask

    task automatic test_reset();
        int bad;
        rst_n = 1'b0;
        fifo_write_req = 1'b0;
        fifo_write_data = '0;
        repeat (3) @(negedge clk);
        tests_run++;
        if (tx_pin !== 1'b1) begin tests_failed++; $display("FAIL reset_tx: tx_pin=%b required 1", tx_pin); end
        tests_run++;
        if (tx_busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy: tx_busy=%b required 0", tx_busy); end
        tests_run++;
        if (full !== 1'b0) begin tests_failed++; $display("FAIL reset_full: full=%b required 0", full); end
        rst_n = 1'b1;
        bad = 0;
        repeat (20) begin
            @(negedge clk);
            if (tx_pin !== 1'b1 || tx_busy !== 1'b0) bad++;
        end
        tests_run++;
        if (bad != 0) begin tests_failed++; $display("FAIL reset_idle: %0d non-idle cycles, required 0", bad); end
    endtask

    task automatic test_single();
        write_byte(8'hAA);
        @(negedge clk);
        tests_run++;
        if (tx_pin !== 1'b1) begin tests_failed++; $display("FAIL single_latency1: tx_pin=%b required 1", tx_pin); end
        @(negedge clk);
        check_frame(8'hAA, 1'b0, "single_aa");
        @(negedge clk);
        tests_run++;
        if (tx_pin !== 1'b1 || tx_busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL single_end: tx_pin=%b tx_busy=%b required 1 0", tx_pin, tx_busy);
        end
    endtask

    task automatic test_back_to_back();
        fifo_write_req  = 1'b1;
        fifo_write_data = 8'hAA;
        @(negedge clk);
        fifo_write_data = 8'h55;
        @(negedge clk);
        fifo_write_req  = 1'b0;
        tests_run++;
        if (tx_pin !== 1'b1) begin tests_failed++; $display("FAIL b2b_latency1: tx_pin=%b required 1", tx_pin); end
        @(negedge clk);
        check_frame(8'hAA, 1'b0, "b2b_aa");
        @(negedge clk);
        tests_run++;
        if (tx_pin !== 1'b1) begin tests_failed++; $display("FAIL b2b_gap: tx_pin=%b required 1", tx_pin); end
        @(negedge clk);
        check_frame(8'h55, 1'b0, "b2b_55");
        @(negedge clk);
        tests_run++;
        if (tx_pin !== 1'b1 || tx_busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL b2b_end: tx_pin=%b tx_busy=%b required 1 0", tx_pin, tx_busy);
        end
    endtask

`ifdef UART_TX_PARITY_EN
    task automatic test_parity();
        write_byte(8'h07);
        @(negedge clk);
        @(negedge clk);
        check_frame(8'h07, 1'b1, "par_07");
        @(negedge clk);
        tests_run++;
        if (tx_pin !== 1'b1 || tx_busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL par_07_end: tx_pin=%b tx_busy=%b required 1 0", tx_pin, tx_busy);
        end
        write_byte(8'h03);
        @(negedge clk);
        @(negedge clk);
        check_frame(8'h03, 1'b0, "par_03");
        @(negedge clk);
        tests_run++;
        if (tx_pin !== 1'b1 || tx_busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL par_03_end: tx_pin=%b tx_busy=%b required 1 0", tx_pin, tx_busy);
        end
    endtask
`endif

    // 0xFF in flight while 0x00..0x10 are written on consecutive cycles.
    task automatic test_full_drop();
        write_byte(8'hFF);
        @(negedge clk);
        @(negedge clk);
        fork
            check_frame(8'hFF, 1'b0, "full_ff");
            begin
                for (int i = 0; i < 17; i++) begin
                    fifo_write_req  = 1'b1;
                    fifo_write_data = 8'(i);
                    @(negedge clk);
                    if (i == 14) begin
                        tests_run++;
                        if (full !== 1'b0) begin tests_failed++; $display("FAIL full_after15: full=%b required 0", full); end
                    end
                    if (i == 15) begin
                        tests_run++;
                        if (full !== 1'b1) begin tests_failed++; $display("FAIL full_after16: full=%b required 1", full); end
                    end
                    if (i == 16) begin
                        tests_run++;
                        if (full !== 1'b1) begin tests_failed++; $display("FAIL full_after17: full=%b required 1", full); end
                    end
                end
                fifo_write_req = 1'b0;
            end
        join
    endtask

    // Entered at the last stop-bit sample of 0xFF; the next edge is the IDLE pop.
    task automatic test_full_pop_collision();
        tests_run++;
        if (full !== 1'b1) begin tests_failed++; $display("FAIL coll_pre_full: full=%b required 1", full); end
        fifo_write_req  = 1'b1;
        fifo_write_data = 8'hEE;
        @(negedge clk);
        fifo_write_req  = 1'b0;
        tests_run++;
        if (full !== 1'b0) begin tests_failed++; $display("FAIL coll_full: full=%b required 0", full); end
        tests_run++;
        if (tx_pin !== 1'b1) begin tests_failed++; $display("FAIL coll_gap: tx_pin=%b required 1", tx_pin); end
    endtask

    // Drains 0x00..0x0F in order; neither 0x10 nor 0xEE may follow.
    task automatic test_fifo_order();
        int bad;
        logic [7:0] b;
        for (int i = 0; i < 16; i++) begin
            b = 8'(i);
            @(negedge clk);
            check_frame(b, ^b, $sformatf("order_%02h", b));
            @(negedge clk);
            tests_run++;
            if (tx_pin !== 1'b1 || full !== 1'b0) begin
                tests_failed++;
                $display("FAIL order_gap_%0d: tx_pin=%b full=%b required 1 0", i, tx_pin, full);
            end
        end
        tests_run++;
        if (tx_busy !== 1'b0) begin tests_failed++; $display("FAIL order_end_busy: tx_busy=%b required 0", tx_busy); end
        bad = 0;
        repeat (300) begin
            @(negedge clk);
            if (tx_pin !== 1'b1 || tx_busy !== 1'b0) bad++;
        end
        tests_run++;
        if (bad != 0) begin tests_failed++; $display("FAIL order_quiet: %0d active cycles, required 0", bad); end
    endtask

    task automatic test_reset_mid_frame();
        int bad;
        for (int i = 0; i < 5; i++) begin
            fifo_write_req  = 1'b1;
            fifo_write_data = 8'h11 + 8'(i);
            @(negedge clk);
        end
        fifo_write_req = 1'b0;
        // 0x11 started low 2 cycles after the first accept; land mid data bit 3.
        repeat (468) @(negedge clk);
        tests_run++;
        if (tx_pin !== 1'b0 || tx_busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL rst_mid_pre: tx_pin=%b tx_busy=%b required 0 1", tx_pin, tx_busy);
        end
        rst_n = 1'b0;
        #1;
        tests_run++;
        if (tx_pin !== 1'b1) begin tests_failed++; $display("FAIL rst_mid_tx: tx_pin=%b required 1", tx_pin); end
        tests_run++;
        if (tx_busy !== 1'b0) begin tests_failed++; $display("FAIL rst_mid_busy: tx_busy=%b required 0", tx_busy); end
        tests_run++;
        if (full !== 1'b0) begin tests_failed++; $display("FAIL rst_mid_full: full=%b required 0", full); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        bad = 0;
        repeat (400) begin
            @(negedge clk);
            if (tx_pin !== 1'b1 || tx_busy !== 1'b0) bad++;
        end
        tests_run++;
        if (bad != 0) begin tests_failed++; $display("FAIL rst_mid_quiet: %0d active cycles, required 0", bad); end
    endtask

    initial begin
        clk             = 1'b0;
        rst_n           = 1'b0;
        fifo_write_req  = 1'b0;
        fifo_write_data = '0;
        tests_run       = 0;
        tests_failed    = 0;
        test_reset();
        test_single();
        test_back_to_back();
`ifdef UART_TX_PARITY_EN
        test_parity();
`endif
        test_full_drop();
        test_full_pop_collision();
        test_fifo_order();
        test_reset_mid_frame();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
